// File: rtl/flappy_pkg.sv
// Shared Flappy-VGA constants, state encoding and small helpers.
// Imported by every block in the game pipeline.
package flappy_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int GROUND_Y     = 440;
  localparam int PIPE_W       = 40;
  localparam int PIPE_SPACING = 320;
  localparam int GAP_MIN      = 40;
  localparam int GAP_H        = 120;
  localparam int SCORE_MAX    = 999;
  localparam int XW           = 10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One-hot so the q_* state outputs come straight from flops.
  typedef enum logic [2:0] {
    ST_INITIAL = 3'b001,
    ST_RUN     = 3'b010,
    ST_OVER    = 3'b100
  } state_t;

  function automatic logic [XW-1:0] x_left(input logic [XW-1:0] xr, input logic [XW-1:0] w);
    return (xr > w) ? xr - w : '0;
  endfunction

endpackage

// File: rtl/pipe_engine_if.sv
// Bus between the pipe engine and its neighbours: control, bird box in,
// pipe rectangles, score and state out.
interface pipe_engine_if;
  import flappy_pkg::*;

  logic          Start;
  logic          Ack;
  logic [XW-1:0] Bird_X_L;
  logic [XW-1:0] Bird_X_R;
  logic [XW-1:0] Bird_Y_T;
  logic [XW-1:0] Bird_Y_B;
  logic [XW-1:0] Pipe0_X_L;
  logic [XW-1:0] Pipe0_X_R;
  logic [XW-1:0] Pipe0_Gap_T;
  logic [XW-1:0] Pipe0_Gap_B;
  logic [XW-1:0] Pipe1_X_L;
  logic [XW-1:0] Pipe1_X_R;
  logic [XW-1:0] Pipe1_Gap_T;
  logic [XW-1:0] Pipe1_Gap_B;
  logic [XW-1:0] Score;
  logic          Collision;
  logic          q_Initial;
  logic          q_Run;
  logic          q_Over;

  modport master (
    output Start, Ack, Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B,
    input  Pipe0_X_L, Pipe0_X_R, Pipe0_Gap_T, Pipe0_Gap_B,
    input  Pipe1_X_L, Pipe1_X_R, Pipe1_Gap_T, Pipe1_Gap_B,
    input  Score, Collision, q_Initial, q_Run, q_Over
  );

  modport slave (
    input  Start, Ack, Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B,
    output Pipe0_X_L, Pipe0_X_R, Pipe0_Gap_T, Pipe0_Gap_B,
    output Pipe1_X_L, Pipe1_X_R, Pipe1_Gap_T, Pipe1_Gap_B,
    output Score, Collision, q_Initial, q_Run, q_Over
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting.
// Only reset reseeds it, so gap sequences depend on when play starts.
module lfsr16
  import flappy_pkg::*;
(
  input  logic        Clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_reg;
  logic        feedback;

  assign feedback = q_reg[0] ^ q_reg[2] ^ q_reg[3] ^ q_reg[5];

  always_ff @(posedge Clk) begin
    if (reset) begin
      q_reg <= LFSR_SEED;
    end else begin
      q_reg <= {feedback, q_reg[15:1]};
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_engine.sv
// Scrolling two-pipe generator with scoring and collision detection.
// Game state machine plus per-pipe scroll/respawn datapath; all outputs registered.
module pipe_engine #(
  parameter int SCREEN_W     = flappy_pkg::SCREEN_W,
  parameter int PIPE_W       = flappy_pkg::PIPE_W,
  parameter int PIPE_SPACING = flappy_pkg::PIPE_SPACING,
  parameter int GAP_MIN      = flappy_pkg::GAP_MIN,
  parameter int GAP_H        = flappy_pkg::GAP_H,
  parameter int GROUND_Y     = flappy_pkg::GROUND_Y,
  parameter int TICK_DIV     = 250000
) (
  input  logic         Clk,
  input  logic         reset,
  pipe_engine_if.slave bus
);
  import flappy_pkg::*;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [XW-1:0] GAP_T_INIT = XW'(GAP_MIN + 128);
  localparam logic [XW-1:0] GAP_B_INIT = XW'(GAP_MIN + 128 + GAP_H);
  localparam logic [1:0][XW-1:0] XR_INIT = {XW'(SCREEN_W + PIPE_W + PIPE_SPACING),
                                            XW'(SCREEN_W + PIPE_W)};
  localparam logic [1:0][XW-1:0] XL_INIT = {x_left(XR_INIT[1], XW'(PIPE_W)),
                                            x_left(XR_INIT[0], XW'(PIPE_W))};

  state_t               state_reg, state_next;
  logic                 collision_reg, collision_next;
  logic [XW-1:0]        score_reg, score_next;
  logic [XW:0]          score_sum;
  logic [TW-1:0]        tick_reg, tick_next;
  logic [1:0][XW-1:0]   xr_reg, xr_next;
  logic [1:0][XW-1:0]   xl_reg, xl_next;
  logic [1:0][XW-1:0]   gap_t_reg, gap_t_next;
  logic [1:0][XW-1:0]   gap_b_reg, gap_b_next;
  logic [1:0]           scored_reg, scored_next;

  logic [15:0]          lfsr_q;
  logic                 unused_lfsr_hi;
  logic [1:0][XW-1:0]   xr_dec, xr_step, gap_t_step;
  logic [1:0]           respawn, pipe_hit, qualify;
  logic                 hit, step;

  lfsr16 u_lfsr (
    .Clk   (Clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[15:8];

  // Per-pipe scroll, respawn, hit and score qualification.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
    localparam int OTHER = 1 - gi;

    assign respawn[gi]    = (xr_reg[gi] == '0);
    assign xr_dec[gi]     = respawn[gi] ? '0 : xr_reg[gi] - 1'b1;
    // A respawning pipe lines up behind the other pipe's post-step position.
    assign xr_step[gi]    = respawn[gi] ? xr_dec[OTHER] + XW'(PIPE_SPACING) : xr_dec[gi];
    assign gap_t_step[gi] = respawn[gi] ? XW'(GAP_MIN) + {{(XW-8){1'b0}}, lfsr_q[7:0]}
                                        : gap_t_reg[gi];
    assign pipe_hit[gi]   = (bus.Bird_X_R >= xl_reg[gi]) && (bus.Bird_X_L <= xr_reg[gi]) &&
                            ((bus.Bird_Y_T < gap_t_reg[gi]) || (bus.Bird_Y_B > gap_b_reg[gi]));
    assign qualify[gi]    = (xr_reg[gi] < bus.Bird_X_L) && !scored_reg[gi];
  end

  assign hit  = (state_reg == ST_RUN) &&
                ((bus.Bird_Y_B >= XW'(GROUND_Y)) || (|pipe_hit));
  assign step = (state_reg == ST_RUN) && !hit && (tick_reg == TICK_LAST);

  always_comb begin
    state_next     = state_reg;
    collision_next = 1'b0;
    score_next     = score_reg;
    tick_next      = tick_reg;
    xr_next        = xr_reg;
    gap_t_next     = gap_t_reg;
    scored_next    = scored_reg;
    score_sum      = {1'b0, score_reg} + {{XW{1'b0}}, qualify[0]} + {{XW{1'b0}}, qualify[1]};

    case (state_reg)
      ST_INITIAL: begin
        if (bus.Start) begin
          state_next = ST_RUN;
          score_next = '0;
        end
      end
      ST_RUN: begin
        if (hit) begin
          state_next     = ST_OVER;
          collision_next = 1'b1;
        end else begin
          tick_next   = (tick_reg == TICK_LAST) ? '0 : tick_reg + 1'b1;
          score_next  = (score_sum > (XW+1)'(SCORE_MAX)) ? XW'(SCORE_MAX) : score_sum[XW-1:0];
          scored_next = scored_reg | qualify;
          if (step) begin
            xr_next     = xr_step;
            gap_t_next  = gap_t_step;
            scored_next = scored_next & ~respawn;
          end
        end
      end
      ST_OVER: begin
        if (bus.Ack) begin
          state_next  = ST_INITIAL;
          xr_next     = XR_INIT;
          gap_t_next  = {2{GAP_T_INIT}};
          tick_next   = '0;
          scored_next = '0;
        end
      end
      default: state_next = ST_INITIAL;
    endcase

    for (int i = 0; i < 2; i++) begin
      xl_next[i]    = x_left(xr_next[i], XW'(PIPE_W));
      gap_b_next[i] = gap_t_next[i] + XW'(GAP_H);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_reg     <= ST_INITIAL;
      collision_reg <= 1'b0;
      score_reg     <= '0;
      tick_reg      <= '0;
      xr_reg        <= XR_INIT;
      xl_reg        <= XL_INIT;
      gap_t_reg     <= {2{GAP_T_INIT}};
      gap_b_reg     <= {2{GAP_B_INIT}};
      scored_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      collision_reg <= collision_next;
      score_reg     <= score_next;
      tick_reg      <= tick_next;
      xr_reg        <= xr_next;
      xl_reg        <= xl_next;
      gap_t_reg     <= gap_t_next;
      gap_b_reg     <= gap_b_next;
      scored_reg    <= scored_next;
    end
  end

  assign bus.Pipe0_X_L   = xl_reg[0];
  assign bus.Pipe0_X_R   = xr_reg[0];
  assign bus.Pipe0_Gap_T = gap_t_reg[0];
  assign bus.Pipe0_Gap_B = gap_b_reg[0];
  assign bus.Pipe1_X_L   = xl_reg[1];
  assign bus.Pipe1_X_R   = xr_reg[1];
  assign bus.Pipe1_Gap_T = gap_t_reg[1];
  assign bus.Pipe1_Gap_B = gap_b_reg[1];
  assign bus.Score       = score_reg;
  assign bus.Collision   = collision_reg;
  assign bus.q_Initial   = state_reg[0];
  assign bus.q_Run       = state_reg[1];
  assign bus.q_Over      = state_reg[2];

endmodule
